// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider: ratio loaded over a valid/ready port and applied
// only at period boundaries, so clk_out_o never produces runt pulses.
module clk_div_ctrl #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             cfg_valid_i,
    input  logic [WIDTH-1:0] cfg_div_i,
    output logic             cfg_ready_o,
    output logic             cfg_err_o,
    output logic             applied_o,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic             running_o
);

    typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] div_act_q, div_act_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             applied_q, applied_d;
    logic             cfg_err_q, cfg_err_d;

    logic [WIDTH-1:0] lo_len, hi_len, phase_len;
    logic             phase_last, period_end;
    logic             accept, cfg_bad;

    // Odd ratios give the extra cycle to the high phase; len-1 never overflows.
    assign lo_len     = div_act_q >> 1;
    assign hi_len     = div_act_q - lo_len;
    assign phase_len  = clk_out_q ? hi_len : lo_len;
    assign phase_last = (cnt_q == phase_len - WIDTH'(1));
    assign period_end = !clk_out_q && phase_last;

    assign accept  = cfg_valid_i && !pend_q;
    assign cfg_bad = (cfg_div_i < WIDTH'(2));

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            div_act_q  <= WIDTH'(DEFAULT_DIV);
            pend_div_q <= '0;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            applied_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_act_q  <= div_act_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            applied_q  <= applied_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (enable_i) state_d = StRun;
            StRun:  if (!enable_i) state_d = StStop;
            StStop: begin
                if (enable_i) begin
                    state_d = StRun;
                end else if (period_end) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        clk_out_d  = clk_out_q;
        tick_d     = 1'b0;
        applied_d  = 1'b0;
        cfg_err_d  = accept && cfg_bad;
        div_act_d  = div_act_q;
        pend_d     = pend_q;
        pend_div_d = pend_div_q;

        if (state_q == StIdle) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
            if (accept && !cfg_bad) begin
                div_act_d = cfg_div_i;
                applied_d = 1'b1;
            end
            if (enable_i) begin
                clk_out_d = 1'b1;
                tick_d    = 1'b1;
            end
        end else begin
            if (phase_last) begin
                cnt_d     = '0;
                clk_out_d = !clk_out_q;
                tick_d    = !clk_out_q;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
            if (period_end && pend_q) begin
                div_act_d = pend_div_q;
                pend_d    = 1'b0;
                applied_d = 1'b1;
            end
            if (accept && !cfg_bad) begin
                pend_d     = 1'b1;
                pend_div_d = cfg_div_i;
            end
            // Leaving STOP at the period end holds clk_out low instead of starting a new high.
            if (state_d == StIdle) begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
                tick_d    = 1'b0;
            end
        end
    end

    assign cfg_ready_o = !pend_q;
    assign cfg_err_o   = cfg_err_q;
    assign applied_o   = applied_q;
    assign clk_out_o   = clk_out_q;
    assign tick_o      = tick_q;
    assign running_o   = (state_q != StIdle);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: a period-position reference model predicts every cycle's outputs
// into a queue; a negedge monitor pops and compares them against the DUT.
module tb_clk_div_ctrl;

    localparam int unsigned WIDTH       = 16;
    localparam int unsigned DEFAULT_DIV = 4;

    logic             clock_in;
    logic             reset;
    logic             enable;
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready, cfg_err, applied, clk_out, tick, running;

    clk_div_ctrl #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .enable_i    (enable),
        .cfg_valid_i (cfg_valid),
        .cfg_div_i   (cfg_div),
        .cfg_ready_o (cfg_ready),
        .cfg_err_o   (cfg_err),
        .applied_o   (applied),
        .clk_out_o   (clk_out),
        .tick_o      (tick),
        .running_o   (running)
    );

    typedef struct packed {
        logic clk;
        logic tick;
        logic applied;
        logic err;
        logic running;
        logic ready;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_last;
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference model: position within the current period, state 0 idle / 1 run / 2 stop.
    int   m_state;
    int   m_n;
    int   m_pos;
    int   m_pend[$];

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    function automatic exp_t reset_vec();
        exp_t e;
        e = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_n     = DEFAULT_DIV;
        m_pos   = 0;
        m_pend.delete();
        m_last  = reset_vec();
    endtask

    task automatic model_step(input logic en, input logic v, input int d);
        exp_t e;
        bit   acc, good, endp;
        e    = '0;
        acc  = v && (m_pend.size() == 0);
        good = acc && (d >= 2);
        e.err = acc && (d < 2);
        if (m_state == 0) begin
            if (good) begin
                m_n = d;
                e.applied = 1'b1;
            end
            if (en) begin
                m_state = 1;
                m_pos   = 0;
                e.tick  = 1'b1;
            end
        end else begin
            endp = (m_pos == m_n - 1);
            if (endp && m_pend.size() > 0) begin
                m_n = m_pend.pop_front();
                e.applied = 1'b1;
            end
            if (good) m_pend.push_back(d);
            if (m_state == 2 && !en && endp) begin
                m_state = 0;
                m_pos   = 0;
            end else begin
                m_state = en ? 1 : 2;
                m_pos   = endp ? 0 : m_pos + 1;
                e.tick  = endp;
            end
        end
        e.clk     = (m_state != 0) && (m_pos < m_n - m_n / 2);
        e.running = (m_state != 0);
        e.ready   = (m_pend.size() == 0);
        m_last    = e;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clock_in);
        if (reset) begin
            model_reset();
            exp_q.push_back(reset_vec());
        end else begin
            model_step(enable, cfg_valid, int'(cfg_div));
        end
        #2;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    endtask

    task automatic bound_fail(input string name, input bit ok);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Asynchronous reset asserted between edges; replace the already-predicted entry.
    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        exp_q.push_back(reset_vec());
        repeat (2) cyc();
        reset = 1'b0;
    endtask

    task automatic write_cfg(input int d);
        cfg_valid = 1'b1;
        cfg_div   = WIDTH'(d);
        cyc();
        cfg_valid = 1'b0;
        cfg_div   = WIDTH'($urandom);
    endtask

    task automatic wait_tick(input int bound);
        int i;
        i = 0;
        do begin
            cyc();
            i++;
        end while (!m_last.tick && i < bound);
        bound_fail("wait_tick", m_last.tick);
    endtask

    task automatic wait_low(input int bound);
        int i;
        i = 0;
        while (m_last.clk && i < bound) begin
            cyc();
            i++;
        end
        bound_fail("wait_low", !m_last.clk);
    endtask

    task automatic wait_idle(input int bound);
        int i;
        i = 0;
        while (m_state != 0 && i < bound) begin
            cyc();
            i++;
        end
        bound_fail("wait_idle", m_state == 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock_in);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("clk_out", clk_out, e.clk);
                chk("tick", tick, e.tick);
                chk("applied", applied, e.applied);
                chk("cfg_err", cfg_err, e.err);
                chk("running", running, e.running);
                chk("cfg_ready", cfg_ready, e.ready);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        model_reset();
        repeat (3) cyc();
        reset = 1'b0;
        repeat (3) cyc();

        // Default ratio 4, then stop in the first high cycle and re-raise during STOP.
        enable = 1'b1;
        repeat (13) cyc();
        wait_tick(10);
        enable = 1'b0;
        repeat (2) cyc();
        enable = 1'b1;
        repeat (6) cyc();
        wait_tick(10);
        enable = 1'b0;
        wait_idle(20);
        repeat (2) cyc();

        // Ratio 5 written in IDLE, then ratio 4 and 6 written while running.
        write_cfg(5);
        enable = 1'b1;
        repeat (16) cyc();
        write_cfg(4);
        repeat (12) cyc();
        wait_tick(10);
        write_cfg(6);
        repeat (20) cyc();

        // Illegal ratios are discarded.
        write_cfg(1);
        repeat (3) cyc();
        write_cfg(0);
        repeat (8) cyc();

        // Reset in the low phase with a ratio pending.
        write_cfg(9);
        wait_low(20);
        do_reset();
        repeat (2) cyc();
        enable = 1'b1;
        repeat (12) cyc();
        enable = 1'b0;
        wait_idle(20);

        // Smallest ratio.
        write_cfg(2);
        enable = 1'b1;
        repeat (10) cyc();
        enable = 1'b0;
        wait_idle(10);

        // Random enable/config traffic.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_div   = WIDTH'($urandom_range(0, 9));
            cyc();
        end
        cfg_valid = 1'b0;
        enable    = 1'b0;
        wait_idle(40);

        // Largest ratio: one full period, then back to IDLE.
        write_cfg(65535);
        enable = 1'b1;
        cyc();
        enable = 1'b0;
        wait_idle(70000);
        repeat (2) cyc();

        @(negedge clock_in);
        #1;
        bound_fail("scoreboard_drained", exp_q.size() == 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
